sliding_window_adder: RTL and testbench
=======================================

Name: sliding_window_adder

Overview:
Parametrised successor to the fixed past-sample adder. Produces the running sum of the last L accepted input samples. L = 2^win_sel is selectable at runtime, up to 2^LOG_W.
- Adds valid qualification, a registered output, a fill/steady state machine and a synchronous clear.
- Sits in the sample datapath ahead of decimation/averaging stages.
- Implementation: a ring buffer plus an add-new/subtract-oldest accumulator. The cost is O(1) adders, independent of window length.

Parameters:
DW, 8, input sample width (unsigned)
LOG_W, 4, log2 of maximum window length; ring buffer depth = 2^LOG_W
SW, DW+LOG_W, derived sum width; holds the full-scale sum with no overflow (not user-set)
SELW, $clog2(LOG_W+1), derived width of win_sel

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  in_data accepted this cycle when high
in_data  input  DW  sample
win_sel  input  SELW  window exponent, legal 0..LOG_W; L = 2^win_sel
clear  input  1  synchronous flush of window state
out_valid  output  1  one-cycle pulse, out_sum updated
out_sum  output  SW  sum of last min(count, L) accepted samples
out_full  output  1  window holds L samples (state STEADY)

Behaviour:
- Reset (asynchronous, takes effect immediately): acc=0, count=0, wr_ptr=0, win_q=0, state=FILL; out_valid=0, out_sum=0, out_full=0. Ring memory is not reset; count gating makes its contents irrelevant.
- win_q is a register holding win_sel, sampled every cycle. A flush cycle is any cycle with clear=1 or win_sel != win_q.
- Flush cycle:
  - acc=0, count=0, wr_ptr=0, state=FILL, out_full=0, out_valid=0, out_sum=0.
  - A sample presented in the same cycle is dropped.
  - win_q takes the new win_sel.
- win_sel > LOG_W is clamped to LOG_W.
- Accept (in_valid=1, not a flush cycle):
  - mem[wr_ptr] <= in_data; wr_ptr increments modulo 2^LOG_W.
  - FILL: acc <= acc + in_data; count++.
  - STEADY: acc <= acc + in_data - mem[(wr_ptr - L) mod 2^LOG_W].
  - The old entry is read combinationally before the same-edge write. This matters when L = 2^LOG_W, because the read and write addresses are then equal and the old value must be returned.
- Latency: out_sum/out_valid are registered. They reflect the sample accepted on the previous edge, i.e. one cycle of latency.
- Bubbles (in_valid=0): no state change. out_valid=0, out_sum holds.
- State machine:
  - FILL -> STEADY on the accept that makes count == L; out_full=1 in the same cycle as that out_valid.
  - STEADY -> FILL only on flush or reset.
  - win_sel=0 (L=1): the first accept enters STEADY, and from then on out_sum equals the previous input.
- Arithmetic: unsigned, width SW throughout. The subtraction never underflows, because acc always contains the subtracted sample.
- count width is LOG_W+1 and saturates at L.

Optional Feature:
SWA_AVG_EN:
- Defined: adds output out_avg[DW-1:0] = out_sum >> win_q (truncating), registered alongside out_sum, reset 0, cleared on flush.
- Undefined: port and logic absent; the rest of the behaviour is identical.

Decomposition:
- Package swa_pkg holds:
  - state enum {FILL, STEADY};
  - the SW/SELW derivation functions;
  - the window-length function len(sel)=1<<sel.
- Sub-module swa_ring_buf: 2^LOG_W x DW memory with one synchronous write port and one asynchronous read port, giving read-old-on-collision semantics. The top module instantiates it once.

Test Plan:
1. DW=8, LOG_W=2, win_sel=2; feed 1,2,3,4,5,6 back-to-back -> out_sum 1,3,6,10,14,18; out_full rises with 10; out_valid six single-cycle pulses.
2. LOG_W=4, win_sel=4; feed 255 x 20 -> out_sum reaches 4080 at sample 16 and stays 4080 (no wrap); exercises the read/write address collision.
3. win_sel=2 with 5,5,5,5 in the window; change to 1 with sample 9 presented -> 9 dropped, out_full=0; then 7,8,9 -> 7,15,17.
4. clear=1 together with in_valid=1, in_data=40 mid-STEADY -> out_valid=0, sum flushed; next sample 3 -> out_sum 3, state FILL.
5. Window 4 with random in_valid gaps -> out_sum matches a reference model of the last 4 accepted samples; bubbles hold out_sum.
6. Assert rst between clock edges mid-STEADY -> outputs 0 immediately; after release, the first sample restarts FILL. With SWA_AVG_EN, the test 1 sequence gives out_avg 0,0,1,2,3,4.

Source files
------------

// File: rtl/swa_pkg.sv
// Shared types and width helpers for the sliding window adder.
// The optional averaged output is controlled by the SWA_AVG_EN macro in the top module.
package swa_pkg;

  typedef enum logic {
    FILL   = 1'b0,
    STEADY = 1'b1
  } swa_state_e;

  // Full-scale sum of 2^log_w samples of dw bits never exceeds dw+log_w bits.
  function automatic int swa_sum_width(input int dw, input int log_w);
    return dw + log_w;
  endfunction

  function automatic int swa_sel_width(input int log_w);
    return $clog2(log_w + 1);
  endfunction

  function automatic int win_len(input int sel);
    return 1 << sel;
  endfunction

endpackage

// File: rtl/swa_ring_buf.sv
// Sample history memory: one synchronous write port, one asynchronous read port.
// A read at the address being written returns the old contents (read-before-write).
module swa_ring_buf #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [(1<<AW)];

  // Contents are never reset; the fill counter keeps stale entries out of the sum.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sliding_window_adder.sv
// Running sum of the last 2^win_sel accepted samples (ring buffer + add-new/subtract-oldest).
// Define SWA_AVG_EN to add the registered out_avg = out_sum >> window exponent.
module sliding_window_adder
  import swa_pkg::*;
#(
  parameter  int DW    = 8,
  parameter  int LOG_W = 4,
  localparam int SW    = swa_sum_width(DW, LOG_W),
  localparam int SELW  = swa_sel_width(LOG_W)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  input  logic [SELW-1:0] win_sel,
  input  logic            clear,
  output logic            out_valid,
  output logic [SW-1:0]   out_sum,
  output logic            out_full
`ifdef SWA_AVG_EN
  ,
  output logic [DW-1:0]   out_avg
`endif
);

  localparam int AW = LOG_W;
  localparam logic [SELW-1:0] MAX_SEL = SELW'(LOG_W);

  swa_state_e      state_q, state_d;
  logic [SW-1:0]   acc_q, acc_d;
  logic [LOG_W:0]  count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [SELW-1:0] win_q;
  logic            out_valid_q, out_valid_d;

  logic            flush;
  logic            accept;
  logic [SELW-1:0] sel_eff;
  logic [LOG_W:0]  len_w;
  logic [AW-1:0]   rd_addr;
  logic [DW-1:0]   rd_data;

  // A changed window setting invalidates the history just like an explicit clear.
  assign flush   = clear | (win_sel != win_q);
  assign accept  = in_valid & ~flush;
  assign sel_eff = (win_q > MAX_SEL) ? MAX_SEL : win_q;
  assign len_w   = (LOG_W+1)'(win_len(int'(sel_eff)));
  // At the maximum window the low address bits of L are zero, so this aliases wr_ptr.
  assign rd_addr = wr_ptr_q - len_w[AW-1:0];

  swa_ring_buf #(
    .DW (DW),
    .AW (AW)
  ) u_ring (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    out_valid_d = 1'b0;
    if (flush) begin
      state_d  = FILL;
      acc_d    = '0;
      count_d  = '0;
      wr_ptr_d = '0;
    end else if (in_valid) begin
      out_valid_d = 1'b1;
      wr_ptr_d    = wr_ptr_q + AW'(1);
      unique case (state_q)
        FILL: begin
          acc_d   = acc_q + SW'(in_data);
          count_d = count_q + (LOG_W+1)'(1);
          if (count_d == len_w) state_d = STEADY;
        end
        STEADY: begin
          acc_d = acc_q + SW'(in_data) - SW'(rd_data);
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      acc_q       <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      win_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      win_q       <= win_sel;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign out_full  = (state_q == STEADY);

`ifdef SWA_AVG_EN
  logic [DW-1:0] avg_q, avg_d;

  always_comb begin
    avg_d = avg_q;
    if (flush)       avg_d = '0;
    else if (accept) avg_d = DW'(acc_d >> sel_eff);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) avg_q <= '0;
    else     avg_q <= avg_d;
  end

  assign out_avg = avg_q;
`endif

endmodule

// File: tb/tb_sliding_window_adder.sv
// Directed bench for sliding_window_adder (DW=8, LOG_W=4); out_avg checked when SWA_AVG_EN is defined.
module tb_sliding_window_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [2:0]  win_sel;
  logic        clear;
  logic        out_valid;
  logic [11:0] out_sum;
  logic        out_full;
`ifdef SWA_AVG_EN
  logic [7:0]  out_avg;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sliding_window_adder #(
    .DW    (8),
    .LOG_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .win_sel   (win_sel),
    .clear     (clear),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_full  (out_full)
`ifdef SWA_AVG_EN
    ,
    .out_avg   (out_avg)
`endif
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int v, input int s, input int f);
    chk({tag, "_valid"}, int'(out_valid), v);
    chk({tag, "_sum"},   int'(out_sum),   s);
    chk({tag, "_full"},  int'(out_full),  f);
  endtask

  int t1_sum  [6] = '{1, 3, 6, 10, 14, 18};
  int t1_full [6] = '{0, 0, 0, 1, 1, 1};
  int t1_avg  [6] = '{0, 0, 1, 2, 3, 4};
  int t5_v    [12] = '{1, 0, 1, 1, 0, 0, 1, 1, 0, 1, 1, 1};
  int t5_d    [12] = '{10, 99, 20, 30, 98, 97, 40, 50, 96, 60, 70, 80};
  int t5_sum  [12] = '{10, 10, 30, 60, 60, 60, 100, 140, 140, 180, 220, 260};
  int t5_full [12] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    win_sel  = 3'd0;
    clear    = 1'b0;
    #12;
    chk_out("reset", 0, 0, 0);
`ifdef SWA_AVG_EN
    chk("reset_avg", int'(out_avg), 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Window 4: 1..6 back-to-back
    win_sel = 3'd2;
    cyc(1'b0, 8'd0);
    chk("t1_flush_valid", int'(out_valid), 0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 8'(i + 1));
      chk_out($sformatf("t1_s%0d", i), 1, t1_sum[i], t1_full[i]);
`ifdef SWA_AVG_EN
      chk($sformatf("t1_avg%0d", i), int'(out_avg), t1_avg[i]);
`endif
    end
    cyc(1'b0, 8'd0);
    chk_out("t1_bubble", 0, 18, 1);

    // Window now 3,4,5,6; four 5s leave 5,5,5,5
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'd5);
    chk_out("t3_pre", 1, 20, 1);

    // Window change with a sample presented: sample dropped, state flushed
    win_sel = 3'd1;
    cyc(1'b1, 8'd9);
    chk_out("t3_flush", 0, 0, 0);
    cyc(1'b1, 8'd7);
    chk_out("t3_a", 1, 7, 0);
    cyc(1'b1, 8'd8);
    chk_out("t3_b", 1, 15, 1);
    cyc(1'b1, 8'd9);
    chk_out("t3_c", 1, 17, 1);

    // Clear with a simultaneous sample mid-STEADY
    clear = 1'b1;
    cyc(1'b1, 8'd40);
    clear = 1'b0;
    chk_out("t4_clear", 0, 0, 0);
    cyc(1'b1, 8'd3);
    chk_out("t4_after", 1, 3, 0);

    // Window 1: output is the most recent sample
    win_sel = 3'd0;
    cyc(1'b0, 8'd0);
    cyc(1'b1, 8'd7);
    chk_out("l1_a", 1, 7, 1);
    cyc(1'b1, 8'd9);
    chk_out("l1_b", 1, 9, 1);
    cyc(1'b1, 8'd2);
    chk_out("l1_c", 1, 2, 1);

    // Maximum window, full-scale samples, read/write address collision
    win_sel = 3'd4;
    cyc(1'b0, 8'd0);
    for (int k = 1; k <= 20; k++) begin
      cyc(1'b1, 8'd255);
      if (k == 15 || k == 16 || k == 20)
        chk_out($sformatf("t2_k%0d", k), 1, (k < 16 ? k : 16) * 255, (k >= 16) ? 1 : 0);
    end
`ifdef SWA_AVG_EN
    chk("t2_avg", int'(out_avg), 255);
`endif

    // Out-of-range exponent clamps to the maximum window of 16
    win_sel = 3'd7;
    cyc(1'b0, 8'd0);
    chk_out("clamp_flush", 0, 0, 0);
    for (int k = 1; k <= 18; k++) begin
      cyc(1'b1, 8'd1);
      if (k == 15 || k == 16 || k == 18)
        chk_out($sformatf("clamp_k%0d", k), 1, (k < 16 ? k : 16), (k >= 16) ? 1 : 0);
    end

    // Window 4 with valid gaps
    win_sel = 3'd2;
    cyc(1'b0, 8'd0);
    for (int i = 0; i < 12; i++) begin
      cyc(1'(t5_v[i]), 8'(t5_d[i]));
      chk_out($sformatf("t5_c%0d", i), t5_v[i], t5_sum[i], t5_full[i]);
    end

    // Asynchronous reset between edges mid-STEADY
    rst = 1'b1;
    #2;
    chk_out("t6_rst", 0, 0, 0);
    #1;
    rst = 1'b0;
    cyc(1'b0, 8'd0);
    chk_out("t6_idle", 0, 0, 0);
    cyc(1'b1, 8'd6);
    chk_out("t6_first", 1, 6, 0);
    cyc(1'b1, 8'd4);
    chk_out("t6_second", 1, 10, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
